foct_mod_dac_gen: RTL and testbench
===================================

# foct_mod_dac_gen

Parametrised FOG modulation generator for the DAC path. It produces a square-wave bias modulation with configurable half-period, amplitude and bias slot, adds a closed-loop digital staircase ramp with 2π reset, and drives an offset-binary DAC code plus the demodulation strobes. It sits between the demodulator/loop filter, which supplies the ramp step, and the DAC pins. It succeeds the fixed 6-slot driver with runtime config, a step handshake, saturation and reset reporting.

## Interface
- DW, 16: DAC/data width.
- HALF_CYC, 3: clocks per modulation half-period, ≥3.
- START_DLY, 3000: SETTLE clocks before the ramp runs, ≥1.
- RAMP_DIV, 3: ramp update every RAMP_DIV clocks, ≥1.
- Refin_Clk  in  1  sole clock. Reset is asynchronous and active-high: port `Sys_Rst`.
- Sys_Rst  in  1  async active-high reset.
- sys_start  in  1  synchronous run enable; low forces IDLE.
- cfg_amp  in  DW  signed modulation amplitude; sampled at ph=0.
- cfg_bias  in  DW  signed bias-slot level; sampled at ph=0.
- cfg_bound  in  DW  positive ramp boundary.
- cfg_vreset  in  DW  unsigned 2π reset voltage; must be > cfg_bound.
- ramp_en  in  1  ramp update enable; ramp holds while low.
- step_data  in  DW  signed ramp step.
- step_valid  in  1  step offered.
- step_ready  out  1  step accepted when step_valid && step_ready.
- DAC_CLK  out  1  ~(Refin_Clk & running), where running = state≠IDLE.
- dac_code  out  DW  offset-binary code = saturated sum with MSB inverted.
- de_current  out  1  demod strobe, current-sample window.
- de_temper  out  1  demod strobe, temperature-sample window.
- reset_evt  out  1  one-clock pulse per 2π reset.
- sat_err  out  1  sticky flag; sum was clipped.

## Operation
- FSM: IDLE→SETTLE when sys_start=1. SETTLE→RUN after START_DLY clocks. Any state→IDLE on the first clock with sys_start=0. Sys_Rst forces IDLE asynchronously.
- Reset/IDLE values:
  - dac_code = 2^(DW-1) (0x8000).
  - de_current, de_temper, step_ready, reset_evt, sat_err = 0.
  - DAC_CLK = 1.
  - ph, divider, ramp and held step = 0.
- Phase counter ph runs 0..2·HALF_CYC-1 and wraps, in SETTLE and RUN.
- Square level per ph:
  - ph 0..H-2: +amp.
  - ph H-1: bias.
  - ph H..2H-2: −amp (two's-complement negate, computed at DW+1 bits).
  - ph 2H-1: bias.
- Strobes:
  - de_current=1 for ph ∈ {2H-1, 0}.
  - de_temper=1 for ph ∈ {1, 2H-2}.
- Step handshake:
  - step_ready=1 in RUN only.
  - An accepted step_data is held until the next accept.
  - An accept on a ramp-update clock takes effect from the following update; the update itself uses the old step.
- Ramp, RUN only: divider counts 0..RAMP_DIV-1. When divider=RAMP_DIV-1 and ramp_en=1:
  - n = ramp + step, computed at DW+1 bits.
  - If ramp>0 and n ≥ bound: ramp ← n − vreset, reset_evt pulses.
  - Else if ramp<0 and n ≤ −bound: ramp ← n + vreset, reset_evt pulses.
  - Else ramp ← n.
  - In SETTLE the ramp is held at 0.
- Output sum = square + ramp at DW+2 bits. Clamp to [−2^(DW-1), 2^(DW-1)−1]. On clamp, set sat_err; it clears only on Sys_Rst or IDLE.

## Timing
- Everything is registered on Refin_Clk rising edge.
- Pipeline: stage 1 holds ph/level/ramp; stage 2 holds dac_code and the strobes. Strobes are delayed to align with dac_code.
- Latency: ph=0 in the first SETTLE clock; dac_code = +amp code one clock later.
- Config changes are seen only at ph=0, so there are no mid-period level changes.
- sys_start drop mid-RUN: the next edge gives the IDLE values. The held step and ramp are discarded.
- Any reset_evt is a single clock, registered; it does not align to ph.

## Structure
- Package `foct_pkg`:
  - State enum {IDLE, SETTLE, RUN}.
  - Function zero_code(DW).
  - Default constants DEF_AMP=16'sh102E, DEF_BOUND=16'h6FD2, DEF_VRESET=16'h8170.
- Sub-module `foct_ramp_acc`: divider, step hold/handshake, and 2π-reset accumulator. Outputs ramp and reset_evt.
- Top level: FSM, phase counter, level mux, saturating adder, output register, DAC_CLK gating.

## Test plan
Common parameters: DW=16, H=3, START_DLY=8, RAMP_DIV=3, bias=0.
1. Sys_Rst mid-RUN → same cycle: dac_code=0x8000, DAC_CLK=1, all flags 0.
2. sys_start↑, amp=0x102E, ramp_en=0 → dac_code repeats 0x902E,0x902E,0x8000,0x6FD2,0x6FD2,0x8000. de_current high on codes 6,1; de_temper high on codes 2,5.
3. Change cfg_amp at ph=2 → no effect until the next ph=0.
4. RUN, step=156, bound=0x6FD2, vreset=0x8170 → ramp steps +156 every 3 clocks. Update 184 yields −4432 with a reset_evt pulse.
5. step_valid held on an update clock with a new value → that update uses the old step; the next update uses the new one.
6. amp=0x7000 with the ramp forced to ≈0x6000 → dac_code=0xFFFF and sat_err=1, held until sys_start=0.

Source files
------------

// File: rtl/foct_pkg.sv
// rtl/foct_pkg.sv - shared state type, reset code helper and default FOG settings
package foct_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} foct_state_t;

   localparam logic signed [15:0] DEF_AMP    = 16'sh102E;
   localparam logic        [15:0] DEF_BOUND  = 16'h6FD2;
   localparam logic        [15:0] DEF_VRESET = 16'h8170;

   // Offset-binary code of a zero-volt output: only the MSB set.
   function automatic logic [31:0] zero_code(input int dw);
      return 32'd1 << (dw - 1);
   endfunction

endpackage

// File: rtl/foct_mod_dac_gen_if.sv
// rtl/foct_mod_dac_gen_if.sv - ramp step handshake from the loop filter
interface foct_mod_dac_gen_if #(parameter int DW = 16);
   logic [DW-1:0] step_data;
   logic          step_valid;
   logic          step_ready;

   modport master (output step_data, output step_valid, input step_ready);
   modport slave  (input step_data, input step_valid, output step_ready);
endinterface

// File: rtl/foct_ramp_acc.sv
// rtl/foct_ramp_acc.sv - staircase ramp accumulator with step hold and 2pi reset
module foct_ramp_acc #(
   parameter int DW       = 16,
   parameter int RAMP_DIV = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 active,
   input  logic                 keep,
   input  logic                 ramp_en,
   input  logic [DW-1:0]        step_data,
   input  logic                 step_valid,
   output logic                 step_ready,
   input  logic [DW-1:0]        cfg_bound,
   input  logic [DW-1:0]        cfg_vreset,
   output logic signed [DW-1:0] ramp,
   output logic                 reset_evt
);
   localparam int DVW = $clog2(RAMP_DIV + 1);
   localparam logic [DVW-1:0] DIV_LAST = DVW'(RAMP_DIV - 1);

   logic [DVW-1:0]        div;
   logic [DW-1:0]         step_q;
   logic signed [DW:0]    n, bnd;
   logic signed [DW+1:0]  n_up, n_dn;

   assign step_ready = active;
   assign n    = $signed({ramp[DW-1], ramp}) + $signed({step_q[DW-1], step_q});
   assign bnd  = $signed({1'b0, cfg_bound});
   assign n_up = $signed({n[DW], n}) - $signed({2'b00, cfg_vreset});
   assign n_dn = $signed({n[DW], n}) + $signed({2'b00, cfg_vreset});

   // The update reads step_q before this edge's accept lands, so a new step
   // arriving on an update clock only affects the following update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= '0;
         step_q    <= '0;
         ramp      <= '0;
         reset_evt <= 1'b0;
      end else if (!(active && keep)) begin
         div       <= '0;
         step_q    <= '0;
         ramp      <= '0;
         reset_evt <= 1'b0;
      end else begin
         reset_evt <= 1'b0;
         if (step_valid) step_q <= step_data;
         div <= (div == DIV_LAST) ? '0 : div + 1'b1;
         if (div == DIV_LAST && ramp_en) begin
            if (!ramp[DW-1] && ramp != '0 && n >= bnd) begin
               ramp      <= n_up[DW-1:0];
               reset_evt <= 1'b1;
            end else if (ramp[DW-1] && n <= -bnd) begin
               ramp      <= n_dn[DW-1:0];
               reset_evt <= 1'b1;
            end else begin
               ramp <= n[DW-1:0];
            end
         end
      end
   end
endmodule

// File: rtl/foct_mod_dac_gen.sv
// rtl/foct_mod_dac_gen.sv - FOG square-wave modulation plus staircase ramp to an offset-binary DAC
module foct_mod_dac_gen
   import foct_pkg::*;
#(
   parameter int DW        = 16,
   parameter int HALF_CYC  = 3,
   parameter int START_DLY = 3000,
   parameter int RAMP_DIV  = 3
) (
   input  logic                Refin_Clk,
   input  logic                Sys_Rst,
   input  logic                sys_start,
   input  logic [DW-1:0]       cfg_amp,
   input  logic [DW-1:0]       cfg_bias,
   input  logic [DW-1:0]       cfg_bound,
   input  logic [DW-1:0]       cfg_vreset,
   input  logic                ramp_en,
   foct_mod_dac_gen_if.slave   step,
   output logic                DAC_CLK,
   output logic [DW-1:0]       dac_code,
   output logic                de_current,
   output logic                de_temper,
   output logic                reset_evt,
   output logic                sat_err
);
   localparam int PW = $clog2(2 * HALF_CYC);
   localparam int CW = $clog2(START_DLY + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF_CYC - 1);
   localparam logic [PW-1:0] PH_BIAS  = PW'(HALF_CYC - 1);
   localparam logic [PW-1:0] PH_NEG   = PW'(HALF_CYC);
   localparam logic [PW-1:0] PH_TLATE = PW'(2 * HALF_CYC - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(START_DLY - 1);
   localparam logic [DW-1:0] ZERO     = DW'(zero_code(DW));
   localparam logic signed [DW+1:0] MAXV = $signed({3'b000, {(DW-1){1'b1}}});
   localparam logic signed [DW+1:0] MINV = $signed({3'b111, {(DW-1){1'b0}}});

   foct_state_t          state;
   logic [CW-1:0]        cnt;
   logic [PW-1:0]        ph;
   logic [DW-1:0]        amp_q, bias_q;
   logic signed [DW-1:0] ramp;
   logic signed [DW:0]   square;
   logic signed [DW+1:0] sum;
   logic [DW-1:0]        sat_val;
   logic                 clip;

   foct_ramp_acc #(.DW(DW), .RAMP_DIV(RAMP_DIV)) u_ramp (
      .clk        (Refin_Clk),
      .rst        (Sys_Rst),
      .active     (state == ST_RUN),
      .keep       (sys_start),
      .ramp_en    (ramp_en),
      .step_data  (step.step_data),
      .step_valid (step.step_valid),
      .step_ready (step.step_ready),
      .cfg_bound  (cfg_bound),
      .cfg_vreset (cfg_vreset),
      .ramp       (ramp),
      .reset_evt  (reset_evt)
   );

   assign DAC_CLK = ~(Refin_Clk & (state != ST_IDLE));

   always_comb begin
      square = $signed({amp_q[DW-1], amp_q});
      if (ph == PH_BIAS || ph == PH_LAST) square = $signed({bias_q[DW-1], bias_q});
      else if (ph >= PH_NEG)              square = -$signed({amp_q[DW-1], amp_q});
      sum     = $signed({square[DW], square}) + $signed({{2{ramp[DW-1]}}, ramp});
      clip    = 1'b1;
      sat_val = sum[DW-1:0];
      if (sum > MAXV)      sat_val = MAXV[DW-1:0];
      else if (sum < MINV) sat_val = MINV[DW-1:0];
      else                 clip    = 1'b0;
   end

   always_ff @(posedge Refin_Clk or posedge Sys_Rst) begin
      if (Sys_Rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ph         <= '0;
         amp_q      <= '0;
         bias_q     <= '0;
         dac_code   <= ZERO;
         de_current <= 1'b0;
         de_temper  <= 1'b0;
         sat_err    <= 1'b0;
      end else if (!sys_start) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ph         <= '0;
         dac_code   <= ZERO;
         de_current <= 1'b0;
         de_temper  <= 1'b0;
         sat_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:   begin state <= ST_SETTLE; cnt <= '0; end
            ST_SETTLE: if (cnt == CNT_LAST) state <= ST_RUN; else cnt <= cnt + 1'b1;
            default:   ;
         endcase
         // Config is captured only for the upcoming ph=0 so a period never changes level mid-way.
         if (state == ST_IDLE || ph == PH_LAST) begin
            amp_q  <= cfg_amp;
            bias_q <= cfg_bias;
         end
         if (state != ST_IDLE) begin
            ph         <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            dac_code   <= {~sat_val[DW-1], sat_val[DW-2:0]};
            de_current <= (ph == PH_LAST) || (ph == '0);
            de_temper  <= (ph == PW'(1)) || (ph == PH_TLATE);
            if (clip) sat_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_foct_mod_dac_gen.sv
// tb/tb_foct_mod_dac_gen.sv - directed self-checking bench for foct_mod_dac_gen
module tb_foct_mod_dac_gen;
   import foct_pkg::*;

   logic        Refin_Clk = 1'b0;
   logic        Sys_Rst   = 1'b1;
   logic        sys_start = 1'b0;
   logic [15:0] cfg_amp = '0, cfg_bias = '0, cfg_bound = DEF_BOUND, cfg_vreset = DEF_VRESET;
   logic        ramp_en = 1'b0;
   logic        DAC_CLK, de_current, de_temper, reset_evt, sat_err;
   logic [15:0] dac_code;
   int          checks = 0;
   int          errors = 0;

   foct_mod_dac_gen_if #(.DW(16)) step_if ();

   foct_mod_dac_gen #(.DW(16), .HALF_CYC(3), .START_DLY(8), .RAMP_DIV(3)) dut (
      .Refin_Clk  (Refin_Clk),
      .Sys_Rst    (Sys_Rst),
      .sys_start  (sys_start),
      .cfg_amp    (cfg_amp),
      .cfg_bias   (cfg_bias),
      .cfg_bound  (cfg_bound),
      .cfg_vreset (cfg_vreset),
      .ramp_en    (ramp_en),
      .step       (step_if),
      .DAC_CLK    (DAC_CLK),
      .dac_code   (dac_code),
      .de_current (de_current),
      .de_temper  (de_temper),
      .reset_evt  (reset_evt),
      .sat_err    (sat_err)
   );

   always #5 Refin_Clk = ~Refin_Clk;

   task automatic tick();
      @(posedge Refin_Clk);
      #1;
   endtask

   task automatic chk_code(input string name, input logic [15:0] exp);
      checks++;
      if (dac_code !== exp) begin
         errors++;
         $display("FAIL %s: dac_code got %h expected %h", name, dac_code, exp);
      end
   endtask

   task automatic stop_run();
      sys_start = 1'b0;
      step_if.step_valid = 1'b0;
      ramp_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      step_if.step_data = '0;
      step_if.step_valid = 1'b0;
      tick();
      tick();
      chk_code("reset_code", 16'h8000);
      checks++;
      if ({DAC_CLK, de_current, de_temper, reset_evt, sat_err, step_if.step_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {DAC_CLK, de_current, de_temper, reset_evt, sat_err, step_if.step_ready});
      end
      Sys_Rst = 1'b0;
      tick();
   endtask

   task automatic test_square();
      logic [15:0] exp_code [6] = '{16'h902E, 16'h902E, 16'h8000, 16'h6FD2, 16'h6FD2, 16'h8000};
      logic [1:0]  exp_str  [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
      cfg_amp = DEF_AMP;
      cfg_bias = '0;
      sys_start = 1'b1;
      tick();
      chk_code("first_settle_code", 16'h8000);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_code($sformatf("square_%0d", k), exp_code[k]);
         checks++;
         if ({de_current, de_temper} !== exp_str[k]) begin
            errors++;
            $display("FAIL strobe_%0d: got %b expected %b", k, {de_current, de_temper}, exp_str[k]);
         end
      end
   endtask

   task automatic test_cfg_change();
      tick();
      tick();
      cfg_amp = 16'h0100;
      tick(); chk_code("cfg_bias_slot", 16'h8000);
      tick(); chk_code("cfg_old_neg_a", 16'h6FD2);
      tick(); chk_code("cfg_old_neg_b", 16'h6FD2);
      tick(); chk_code("cfg_bias_slot2", 16'h8000);
      tick(); chk_code("cfg_new_amp", 16'h8100);
   endtask

   task automatic test_async_reset();
      checks++;
      if (DAC_CLK !== 1'b0) begin
         errors++;
         $display("FAIL dac_clk_run: got %b expected 0", DAC_CLK);
      end
      #1 Sys_Rst = 1'b1;
      #1;
      chk_code("async_rst_code", 16'h8000);
      checks++;
      if ({DAC_CLK, de_current, de_temper, reset_evt, sat_err, step_if.step_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL async_rst_flags: got %b expected 100000",
                  {DAC_CLK, de_current, de_temper, reset_evt, sat_err, step_if.step_ready});
      end
      sys_start = 1'b0;
      tick();
      Sys_Rst = 1'b0;
      tick();
   endtask

   task automatic test_ramp_wrap();
      int hit = -1;
      cfg_amp = '0;
      cfg_bias = '0;
      step_if.step_data = 16'd156;
      step_if.step_valid = 1'b1;
      ramp_en = 1'b1;
      sys_start = 1'b1;
      for (int e = 0; e < 700 && hit < 0; e++) begin
         tick();
         if (reset_evt) hit = e;
      end
      checks++;
      if (hit != 560) begin
         errors++;
         $display("FAIL wrap_edge: got %0d expected 560", hit);
      end
      chk_code("wrap_before", 16'hEF84);
      tick();
      chk_code("wrap_after", 16'h6EB0);
      checks++;
      if (reset_evt !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pulse_width: got %b expected 0", reset_evt);
      end
      stop_run();
   endtask

   task automatic test_back_to_back();
      step_if.step_data = 16'd10;
      step_if.step_valid = 1'b1;
      ramp_en = 1'b1;
      sys_start = 1'b1;
      for (int e = 0; e <= 18; e++) begin
         tick();
         if (e == 11) chk_code("b2b_pre", 16'h8000);
         if (e == 12) chk_code("b2b_first", 16'h800A);
         if (e == 13) step_if.step_data = 16'd100;
         if (e == 15) chk_code("b2b_old_step", 16'h8014);
         if (e == 18) chk_code("b2b_new_step", 16'h8078);
      end
      stop_run();
   endtask

   task automatic test_saturation();
      cfg_amp = 16'h7000;
      step_if.step_data = 16'h6000;
      step_if.step_valid = 1'b1;
      ramp_en = 1'b1;
      sys_start = 1'b1;
      for (int e = 0; e <= 16; e++) begin
         tick();
         if (e == 11) ramp_en = 1'b0;
         if (e == 12) begin
            chk_code("sat_bias_slot", 16'hE000);
            checks++;
            if (sat_err !== 1'b0) begin
               errors++;
               $display("FAIL sat_early: got %b expected 0", sat_err);
            end
         end
         if (e == 13) chk_code("sat_clip", 16'hFFFF);
         if (e == 16) begin
            chk_code("sat_neg_slot", 16'h7000);
            checks++;
            if (sat_err !== 1'b1) begin
               errors++;
               $display("FAIL sat_sticky: got %b expected 1", sat_err);
            end
         end
      end
      stop_run();
      chk_code("sat_idle_code", 16'h8000);
      checks++;
      if (sat_err !== 1'b0) begin
         errors++;
         $display("FAIL sat_clear: got %b expected 0", sat_err);
      end
   endtask

   initial begin
      test_reset();
      test_square();
      test_cfg_change();
      test_async_reset();
      test_ramp_wrap();
      test_back_to_back();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
